// File: rtl/debounce_edges.sv
// Debounces a noisy asynchronous level through a two-flop synchronizer and a
// qualification FSM, producing a clean level plus one-clock rise/fall pulses.
module debounce_edges #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic nrst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        P_HIGH = 2'd1,
        S_HIGH = 2'd2,
        P_LOW  = 2'd3
    } state_t;

    state_t           state;
    logic             sync1;
    logic             din_s;
    logic [CNT_W-1:0] cnt;

    // cnt tracks how many consecutive din_s samples have disagreed with dout;
    // the change is accepted on the sample after cnt reaches DEBOUNCE_CYCLES.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            sync1 <= 1'b0;
            din_s <= 1'b0;
            state <= S_LOW;
            cnt   <= CNT_ZERO;
            dout  <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            sync1 <= din;
            din_s <= sync1;
            rise  <= 1'b0;
            fall  <= 1'b0;
            case (state)
                S_LOW: begin
                    if (din_s) begin
                        state <= P_HIGH;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end
                end
                P_HIGH: begin
                    if (!din_s) begin
                        state <= S_LOW;
                        cnt   <= CNT_ZERO;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_MAX) begin
                        state <= S_HIGH;
                        cnt   <= CNT_ZERO;
                        dout  <= 1'b1;
                        rise  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_HIGH: begin
                    if (!din_s) begin
                        state <= P_LOW;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end
                end
                P_LOW: begin
                    if (din_s) begin
                        state <= S_HIGH;
                        cnt   <= CNT_ZERO;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_MAX) begin
                        state <= S_LOW;
                        cnt   <= CNT_ZERO;
                        dout  <= 1'b0;
                        fall  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= S_LOW;
                    cnt   <= CNT_ZERO;
                    dout  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Downstream SR trigger must never see set and reset together.
    a_no_set_reset: assert property (@(posedge clk) !(rise && fall));

endmodule

// File: doc/debounce_edges.md
DEBOUNCE_EDGES -- requirements
Module: debounce_edges

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning the number of consecutive sampled clocks that confirm a level change (legal range 1..65535).
REQ-002 SHALL have port clk  input  1  system clock; all logic is on posedge clk.
REQ-003 SHALL have port nrst  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 SHALL have port din  input  1  raw, noisy, possibly asynchronous level (button, comparator, remote flag).
REQ-005 SHALL have port dout  output  1  debounced level.
REQ-006 SHALL have port rise  output  1  one-clock pulse on each debounced 0->1 change; drives a downstream SR trigger set input.
REQ-007 SHALL have port fall  output  1  one-clock pulse on each debounced 1->0 change; drives a downstream SR trigger reset input.
REQ-008 SHALL have port busy  output  1  high while a level change is being qualified.

Function
REQ-009 SHALL pass din through a two-flop synchronizer (sync1 -> din_s) before any other use; din is never used combinationally.
REQ-010 SHALL implement a 4-state FSM: S_LOW, P_HIGH, S_HIGH, P_LOW.
REQ-011 SHALL hold a qualification counter of width $clog2(DEBOUNCE_CYCLES+1) bits; it never wraps.
REQ-012 S_LOW: din_s=1 -> P_HIGH with cnt=1; din_s=0 -> stay.
REQ-013 P_HIGH: din_s=0 -> S_LOW with cnt=0 (glitch rejected, no pulse); din_s=1 and cnt==DEBOUNCE_CYCLES -> S_HIGH with cnt=0; otherwise cnt+1.
REQ-014 S_HIGH and P_LOW SHALL mirror REQ-012/REQ-013 with polarities inverted.
REQ-015 dout SHALL be registered: 1 in S_HIGH and P_LOW, 0 in S_LOW and P_HIGH.
REQ-016 rise SHALL be high for exactly the one cycle after the P_HIGH->S_HIGH transition edge; fall likewise for P_LOW->S_LOW.
REQ-017 rise and fall SHALL never be high in the same cycle, and never in two consecutive cycles.
REQ-018 busy SHALL be registered, high exactly when the state is P_HIGH or P_LOW.
REQ-019 Latency: if din is high from edge k onward (was low and settled), dout and rise SHALL go high after edge k+DEBOUNCE_CYCLES+2; falling is symmetric.
REQ-020 Acceptance boundary: din stable for >= DEBOUNCE_CYCLES+1 consecutive sampling edges SHALL be accepted; <= DEBOUNCE_CYCLES SHALL be rejected with no output change.
REQ-021 A reversal of din_s during qualification SHALL abort it on that edge, and SHALL NOT carry over partial counts to the next attempt.
REQ-022 After an accepted change, a new change SHALL need a full fresh qualification; there is no hold-off beyond that.

Reset
REQ-023 While nrst=0 at a clock edge, the block SHALL set sync1=0, din_s=0, state=S_LOW, cnt=0, dout=0, rise=0, fall=0, busy=0.
REQ-024 Reset asserted mid-qualification SHALL discard it and emit no pulse; reset SHALL override every other condition in the same cycle.
REQ-025 If din=1 when nrst releases, the block SHALL treat it as a fresh 0->1 change: rise fires after REQ-019 latency counted from the first edge with nrst=1.
REQ-026 No output SHALL change without a clock edge, reset included.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 din 0->1 at edge 10, held -> busy=1 after edge 12, dout=1 and rise=1 after edge 16, rise=0 after edge 17, busy=0 after edge 16.
REQ-028 din high for exactly 4 edges (10..13), then low -> dout stays 0, rise never asserts, busy pulses then returns to 0.
REQ-029 din high for exactly 5 edges (10..14) -> accepted: rise after edge 16; then fall after edge 21 (low from edge 15: 15+4+2).
REQ-030 din toggling every cycle for 100 cycles from dout=1 -> no rise/fall pulse, dout stays 1.
REQ-031 nrst=0 for one edge while in P_HIGH with cnt=3 -> next cycle all outputs 0, state S_LOW, no rise at any later edge unless din requalifies.
REQ-032 Random din for 10^5 cycles -> rise/fall strictly alternate; every pulse has one-cycle width and matches a dout change; dout matches a golden model.
